// File: rtl/reactive_io_pkg.sv
// Shared types and constants for the FlexiCores reactive I/O responder.
package reactive_io_pkg;

  typedef enum logic [4:0] {
    ST_START,
    ST_OTH_0,
    ST_OTH_1,
    ST_OTH_2,
    ST_X_ST,
    ST_L_ST,
    ST_R_ST,
    ST_ARR_0,
    ST_ARR_1,
    ST_ARR_2,
    ST_OP_0,
    ST_OP_1,
    ST_PAGE,
    ST_LOOP,
    ST_RET_0,
    ST_RET_1,
    ST_RET_2,
    ST_DONE
  } state_t;

  localparam logic [1:0] TOK_IDLE  = 2'd0;
  localparam logic [1:0] TOK_OPER  = 2'd1;
  localparam logic [1:0] TOK_OTHER = 2'd2;
  localparam logic [1:0] TOK_END   = 2'd3;

  localparam logic [7:0] BRANCH0_INSTR = 8'b1_000_0000;

  // Offsets of the scalar constants above the array region.
  localparam int CFG_X = 0;
  localparam int CFG_L = 1;
  localparam int CFG_R = 2;

endpackage

// File: rtl/reactive_io_ctrl_cfg_mem.sv
// Configuration register file: array entries followed by the X, L and R constants.
module reactive_cfg_mem
  import reactive_io_pkg::*;
#(
  parameter int DATA_LEN  = 4,
  parameter int ARR_DEPTH = 8,
  parameter int AW        = $clog2(ARR_DEPTH),
  parameter int CW        = $clog2(ARR_DEPTH + 3)
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [CW-1:0]       i_addr,
  input  logic [DATA_LEN-1:0] i_wdata,
  input  logic [AW-1:0]       i_rd_idx,
  output logic [DATA_LEN-1:0] o_rd_data,
  output logic [DATA_LEN-1:0] o_x,
  output logic [DATA_LEN-1:0] o_l,
  output logic [DATA_LEN-1:0] o_r
);

  localparam int DEPTH = ARR_DEPTH + 3;
  localparam logic [CW-1:0] X_ADDR = CW'(ARR_DEPTH + CFG_X);
  localparam logic [CW-1:0] L_ADDR = CW'(ARR_DEPTH + CFG_L);
  localparam logic [CW-1:0] R_ADDR = CW'(ARR_DEPTH + CFG_R);

  logic [DATA_LEN-1:0] r_mem [DEPTH];
  logic                w_addr_ok;

  assign w_addr_ok = (32'(i_addr) < 32'(DEPTH));

  // Storage is deliberately unreset so configuration survives a core restart.
  always_ff @(posedge i_clk) begin
    if (i_we && w_addr_ok) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rd_data = r_mem[CW'(i_rd_idx)];
  assign o_x       = r_mem[X_ADDR];
  assign o_l       = r_mem[L_ADDR];
  assign o_r       = r_mem[R_ADDR];

endmodule

// File: rtl/reactive_io_ctrl.sv
// Token-protocol responder: feeds IPORT, sequences ROM pages and captures the result.
module reactive_io_ctrl
  import reactive_io_pkg::*;
#(
  parameter int DATA_LEN       = 4,
  parameter int PC_LEN         = 7,
  parameter int ARR_DEPTH      = 8,
  parameter int NUM_PAGES      = 2,
  parameter int PAGE_WRAP      = 0,
  parameter int HALT_ON_RETURN = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [DATA_LEN-1:0]            OPORT,
  input  logic [PC_LEN-1:0]              PC,
  output logic [DATA_LEN-1:0]            IPORT,
  output logic [$clog2(NUM_PAGES)-1:0]   page_sel,
  output logic                           force_branch,
  input  logic                           cfg_we,
  input  logic [$clog2(ARR_DEPTH+3)-1:0] cfg_addr,
  input  logic [DATA_LEN-1:0]            cfg_wdata,
  output logic                           result_valid,
  output logic [DATA_LEN-1:0]            result_data,
  output logic                           result_found,
  output logic                           halted,
  output logic                           idx_err
);

  localparam int AW = $clog2(ARR_DEPTH);
  localparam int CW = $clog2(ARR_DEPTH + 3);
  localparam int PW = $clog2(NUM_PAGES);
  localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);

  state_t              r_state;
  logic [DATA_LEN-1:0] r_iport;
  logic [PW-1:0]       r_page;
  logic                r_force;
  logic                r_valid;
  logic [DATA_LEN-1:0] r_rdata;
  logic                r_found;
  logic                r_halted;
  logic                r_idx_err;

  logic [1:0]          w_tok;
  logic                w_oob;
  logic [AW-1:0]       w_idx;
  logic [PW-1:0]       w_page_next;
  logic [DATA_LEN-1:0] w_arr_data;
  logic [DATA_LEN-1:0] w_x;
  logic [DATA_LEN-1:0] w_l;
  logic [DATA_LEN-1:0] w_r;

  assign w_tok = OPORT[1:0];
  assign w_oob = (32'(OPORT) >= 32'(ARR_DEPTH));
  assign w_idx = OPORT[AW-1:0];

  assign w_page_next = (r_page == LAST_PAGE) ? ((PAGE_WRAP != 0) ? '0 : r_page)
                                             : r_page + PW'(1);

  reactive_cfg_mem #(
    .DATA_LEN  (DATA_LEN),
    .ARR_DEPTH (ARR_DEPTH),
    .AW        (AW),
    .CW        (CW)
  ) u_cfg_mem (
    .i_clk     (CLK),
    .i_we      (cfg_we),
    .i_addr    (cfg_addr),
    .i_wdata   (cfg_wdata),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_arr_data),
    .o_x       (w_x),
    .o_l       (w_l),
    .o_r       (w_r)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_START;
      r_iport   <= '0;
      r_page    <= '0;
      r_force   <= 1'b0;
      r_valid   <= 1'b0;
      r_rdata   <= '0;
      r_found   <= 1'b0;
      r_halted  <= 1'b0;
      r_idx_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_tok == TOK_OPER)       r_state <= ST_OP_0;
          else if (w_tok == TOK_OTHER) r_state <= ST_OTH_0;
        end
        ST_OTH_0: begin
          if (w_tok == TOK_IDLE)      r_state <= ST_OTH_2;
          else if (w_tok == TOK_OPER) r_state <= ST_OTH_1;
        end
        ST_OTH_1: begin
          if (w_tok == TOK_IDLE) begin
            r_state <= ST_L_ST;
            r_iport <= w_l;
          end else if (w_tok == TOK_OTHER) begin
            r_state <= ST_X_ST;
            r_iport <= w_x;
          end
        end
        ST_OTH_2: begin
          if (w_tok == TOK_OPER) begin
            r_state <= ST_R_ST;
            r_iport <= w_r;
          end else if (w_tok == TOK_OTHER) begin
            r_state <= ST_ARR_0;
          end
        end
        ST_X_ST, ST_L_ST, ST_R_ST, ST_ARR_2, ST_RET_2, ST_LOOP: begin
          if (w_tok == TOK_END) r_state <= ST_START;
        end
        ST_ARR_0: r_state <= ST_ARR_1;
        ST_ARR_1: begin
          r_state <= ST_ARR_2;
          if (w_oob) begin
            r_iport   <= '0;
            r_idx_err <= 1'b1;
          end else begin
            r_iport <= w_arr_data;
          end
        end
        ST_OP_0: begin
          if (w_tok == TOK_OTHER) r_state <= ST_OP_1;
        end
        ST_OP_1: begin
          if (w_tok == TOK_IDLE) begin
            r_state <= ST_PAGE;
            r_force <= 1'b1;
          end else if (w_tok == TOK_OPER) begin
            r_state <= ST_RET_0;
          end
        end
        // The core is held on BRANCH 0 until its PC lands on zero.
        ST_PAGE: begin
          if (PC == '0) begin
            r_state <= ST_LOOP;
            r_force <= 1'b0;
            r_page  <= w_page_next;
          end
        end
        ST_RET_0: r_state <= ST_RET_1;
        ST_RET_1: begin
          r_rdata <= OPORT;
          r_found <= (OPORT != '1);
          r_valid <= 1'b1;
          if (HALT_ON_RETURN != 0) begin
            r_state  <= ST_DONE;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_RET_2;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_START;
      endcase
    end
  end

  assign IPORT        = r_iport;
  assign page_sel     = r_page;
  assign force_branch = r_force;
  assign result_valid = r_valid;
  assign result_data  = r_rdata;
  assign result_found = r_found;
  assign halted       = r_halted;
  assign idx_err      = r_idx_err;

endmodule

// File: doc/reactive_io_ctrl.md
Name: reactive_io_ctrl

Overview:
- Synthesizable, parametrised I/O responder for the FlexiCores 4-bit core family.
- Watches the core's output port, decodes the OPORT[1:0] token protocol, and drives IPORT with constants or array data.
- Owns ROM page selection: it injects BRANCH 0 until PC reaches 0, then advances the page.
- Captures the program's result. This replaces bench-only reactive logic so silicon or FPGA builds can run multi-page programs unattended.

Parameters:
- DATA_LEN, 4, width of IPORT/OPORT and of array/constant entries.
- PC_LEN, 7, width of the core program counter.
- ARR_DEPTH, 8, number of array entries; a power of two, at most 2**DATA_LEN.
- NUM_PAGES, 2, number of ROM pages (at least 2).
- PAGE_WRAP, 0, 1 = page index wraps to 0 after the last page; 0 = page index saturates at the last page.
- HALT_ON_RETURN, 1, 1 = enter DONE after a result; 0 = return to START.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- OPORT  in  DATA_LEN  core output port.
- PC  in  PC_LEN  core program counter.
- IPORT  out  DATA_LEN  core input port, registered.
- page_sel  out  $clog2(NUM_PAGES)  ROM page select, registered.
- force_branch  out  1  when 1, the ROM mux substitutes 8'b1_000_0000 (BRANCH 0).
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  $clog2(ARR_DEPTH+3)  address map: 0..ARR_DEPTH-1 = array; ARR_DEPTH = X; +1 = L; +2 = R.
- cfg_wdata  in  DATA_LEN  configuration write data.
- result_valid  out  1  one-cycle pulse when a result is captured.
- result_data  out  DATA_LEN  captured OPORT value; held until the next capture.
- result_found  out  1  0 iff result_data is all-ones (sentinel); held with result_data.
- halted  out  1  high in DONE.
- idx_err  out  1  sticky flag: an array index was out of range.

Behaviour:
- Reset values: IPORT=0, page_sel=0, force_branch=0, result_valid=0, result_data=0, result_found=0, halted=0, idx_err=0, state=START. Config storage is not reset.
- RST asserted mid-operation aborts any page change immediately; force_branch drops asynchronously.
- One transition is evaluated per rising edge using the sampled tok = OPORT[1:0]. The FSM stays in the current state unless a listed transition applies.
- Token and fetch states:
  - START: tok 1 -> OP_0; tok 2 -> OTH_0.
  - OTH_0: tok 0 -> OTH_2; tok 1 -> OTH_1.
  - OTH_1: tok 0 -> L_ST with IPORT<=L; tok 2 -> X_ST with IPORT<=X.
  - OTH_2: tok 1 -> R_ST with IPORT<=R; tok 2 -> ARR_0.
  - X_ST, L_ST, R_ST, ARR_2, RET_2, LOOP: tok 3 -> START.
  - ARR_0 -> ARR_1 unconditionally.
  - ARR_1 -> ARR_2 with IPORT<=arr[OPORT]. If OPORT >= ARR_DEPTH, IPORT<=0 and idx_err<=1.
- Operation, paging and return states:
  - OP_0: tok 2 -> OP_1.
  - OP_1: tok 0 -> PAGE; tok 1 -> RET_0.
  - PAGE: force_branch=1 (Moore output of PAGE). When sampled PC==0, the next state is LOOP and page_sel advances by one. At NUM_PAGES-1 the page index wraps to 0 if PAGE_WRAP, otherwise it holds. force_branch is 0 from the cycle LOOP is entered.
  - RET_0 -> RET_1 unconditionally.
  - RET_1: result_data<=OPORT; result_found<=(OPORT != all-ones); result_valid=1 for exactly this cycle's following edge. Next state is DONE if HALT_ON_RETURN, otherwise RET_2.
  - DONE: halted=1; absorbing until RST; OPORT is ignored.
- IPORT holds its last value in all states that do not load it.
- cfg writes are accepted in any state and take effect on the same edge. A read of the same address on that edge returns the old value.
- All array indexing uses OPORT[$clog2(ARR_DEPTH)-1:0] after the range check on the full OPORT.

Decomposition:
- Package reactive_io_pkg holds:
  - the state enum;
  - the token constants TOK_OPER=1, TOK_OTHER=2, TOK_END=3;
  - BRANCH0_INSTR=8'b1_000_0000;
  - config address offsets CFG_X, CFG_L, CFG_R relative to ARR_DEPTH.
- Sub-module reactive_cfg_mem: ARR_DEPTH+3 × DATA_LEN register file with a write port, an indexed array read, and direct X/L/R outputs.

Test Plan:
- Reset mid-PAGE: RST during force_branch=1 -> force_branch=0 immediately; page_sel=0, state START.
- Constant fetch: array {0,1,1,3,4,4,5,6}, X=3. OPORT tokens 2,1,2 -> IPORT=3. Token 2,1,0 -> IPORT=L (0). Token 2,0,1 -> IPORT=7 with R=7. Token 3 -> back to START.
- Array read: tokens 2,0,2, then OPORT=4 on ARR_1 -> IPORT=4. OPORT=9 -> IPORT=0, idx_err=1 (sticky through later reads).
- Page change: tokens 1,2,0 with PC counting down 5..0 -> force_branch high until PC==0 sampled, then page_sel 0->1. With NUM_PAGES=2: PAGE_WRAP=0 gives a second change that holds at 1; PAGE_WRAP=1 wraps to 0.
- Return found: tokens 1,2,1, then OPORT=3 on RET_1 -> result_valid pulse of 1 cycle, result_data=3, result_found=1, halted=1. Further tokens are ignored.
- Return not-found with HALT_ON_RETURN=0: OPORT=15 on RET_1 -> result_found=0, result_data=15, halted=0. Token 3 -> START.
